// File: rtl/alu_74382_slice_seq.sv
// Word-wide ALU built by stepping one external 74382 slice across the operands,
// least-significant slice first, with the carry chained through a register.
module alu_74382_slice_seq #(
  parameter int OPERAND_W = 4,
  parameter int WORD_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_sel,
  input  logic                 req_carry_in,
  input  logic [WORD_W-1:0]    req_a,
  input  logic [WORD_W-1:0]    req_b,
  output logic [2:0]           alu_sel,
  output logic                 alu_carry_in,
  output logic [OPERAND_W-1:0] alu_port_a,
  output logic [OPERAND_W-1:0] alu_port_b,
  input  logic [OPERAND_W-1:0] alu_result,
  input  logic                 alu_overflow,
  input  logic                 alu_carry_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_W-1:0]    rsp_result,
  output logic                 rsp_carry_out,
  output logic                 rsp_overflow
);

  localparam int NSLICE = (OPERAND_W > 0) ? WORD_W / OPERAND_W : 0;
  localparam int REM    = (OPERAND_W > 0) ? WORD_W % OPERAND_W : 1;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (NSLICE < 1 || REM != 0) begin : g_bad_geometry
    $error("WORD_W must be a positive integer multiple of OPERAND_W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg;
  logic [2:0]             sel_reg;
  logic [WORD_W-1:0]      a_reg;
  logic [WORD_W-1:0]      b_reg;
  logic                   carry_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic                   carry_out_reg;
  logic                   overflow_reg;

  logic [OPERAND_W-1:0]   a_slice [NSLICE];
  logic [OPERAND_W-1:0]   b_slice [NSLICE];
  logic [OPERAND_W-1:0]   result_slice_reg [NSLICE];

  // Operand slicing and result assembly, one lane per 74382 slice.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign a_slice[gi] = a_reg[gi*OPERAND_W +: OPERAND_W];
    assign b_slice[gi] = b_reg[gi*OPERAND_W +: OPERAND_W];
    assign rsp_result[gi*OPERAND_W +: OPERAND_W] = result_slice_reg[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        result_slice_reg[gi] <= '0;
      end else if (state_reg == RUN && idx_reg == IDX_W'(gi)) begin
        result_slice_reg[gi] <= alu_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            sel_reg   <= req_sel;
            a_reg     <= req_a;
            b_reg     <= req_b;
            carry_reg <= req_carry_in;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          carry_reg <= alu_carry_out;
          if (idx_reg == LAST_IDX) begin
            // Index parks on the top slice; only a new accept rewinds it.
            carry_out_reg <= alu_carry_out;
            overflow_reg  <= alu_overflow;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_reg == IDLE);
  assign rsp_valid     = (state_reg == DONE);
  assign rsp_carry_out = carry_out_reg;
  assign rsp_overflow  = overflow_reg;

  // The slice ALU sees quiet zeros whenever no operation is in flight.
  always_comb begin
    alu_sel      = 3'b000;
    alu_carry_in = 1'b0;
    alu_port_a   = '0;
    alu_port_b   = '0;
    if (state_reg == RUN) begin
      alu_sel      = sel_reg;
      alu_carry_in = carry_reg;
      alu_port_a   = a_slice[idx_reg];
      alu_port_b   = b_slice[idx_reg];
    end
  end

endmodule

// File: tb/tb_alu_74382_slice_seq.sv
// Scoreboard bench: a behavioural 74382 slice drives the ALU ports, a full-width
// arithmetic model predicts responses, and a monitor checks them on handshake.
module tb_alu_74382_slice_seq;
  localparam int OW = 4;
  localparam int W  = 16;
  localparam int NS = W / OW;

  logic          clk, rst;
  logic          req_valid, req_ready, req_carry_in;
  logic [2:0]    req_sel;
  logic [W-1:0]  req_a, req_b;
  logic [2:0]    alu_sel;
  logic          alu_carry_in;
  logic [OW-1:0] alu_port_a, alu_port_b, alu_result;
  logic          alu_overflow, alu_carry_out;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_carry_out, rsp_overflow;

  alu_74382_slice_seq #(.OPERAND_W(OW), .WORD_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_carry_in(req_carry_in), .req_a(req_a), .req_b(req_b),
    .alu_sel(alu_sel), .alu_carry_in(alu_carry_in),
    .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry_out(rsp_carry_out), .rsp_overflow(rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single 74382 slice (flags are zero for logic/CLEAR/PRESET codes).
  logic [OW:0]   sl_sum;
  logic [OW-1:0] sl_x, sl_y;
  logic          sl_arith;
  always_comb begin
    alu_result = '0; alu_carry_out = 1'b0; alu_overflow = 1'b0;
    sl_x = '0; sl_y = '0; sl_sum = '0; sl_arith = 1'b0;
    case (alu_sel)
      3'b000: alu_result = '0;
      3'b001: begin sl_x = alu_port_b; sl_y = ~alu_port_a; sl_arith = 1'b1; end
      3'b010: begin sl_x = alu_port_a; sl_y = ~alu_port_b; sl_arith = 1'b1; end
      3'b011: begin sl_x = alu_port_a; sl_y = alu_port_b;  sl_arith = 1'b1; end
      3'b100: alu_result = alu_port_a ^ alu_port_b;
      3'b101: alu_result = alu_port_a | alu_port_b;
      3'b110: alu_result = alu_port_a & alu_port_b;
      default: alu_result = '1;
    endcase
    if (sl_arith) begin
      sl_sum        = {1'b0, sl_x} + {1'b0, sl_y} + {{OW{1'b0}}, alu_carry_in};
      alu_result    = sl_sum[OW-1:0];
      alu_carry_out = sl_sum[OW];
      alu_overflow  = (sl_x[OW-1] == sl_y[OW-1]) && (sl_sum[OW-1] != sl_x[OW-1]);
    end
  end

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   bp_mode = 0;

  // Whole-word reference: plain W-bit arithmetic on the full operands.
  function automatic exp_t ref_model(input logic [2:0] sel, input logic ci,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    logic [W-1:0] x, y;
    e = '0; x = '0; y = '0;
    case (sel)
      3'b000: e.r = '0;
      3'b111: e.r = '1;
      3'b100: e.r = a ^ b;
      3'b101: e.r = a | b;
      3'b110: e.r = a & b;
      default: begin
        if (sel == 3'b011) begin x = a; y = b; end
        else if (sel == 3'b010) begin x = a; y = ~b; end
        else begin x = b; y = ~a; end
        s    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.r  = s[W-1:0];
        e.co = s[W];
        e.ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  // Consumer backpressure: random, forced low, or forced high.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops on handshake and checks stability while stalled.
  initial begin
    bit held_valid;
    logic [W+1:0] held;
    exp_t e;
    held_valid = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid)
          chk("hold_stable", 32'({rsp_valid, rsp_result, rsp_carry_out, rsp_overflow}),
              32'({1'b1, held}));
        if (rsp_valid) begin
          chk("done_req_ready", 32'(req_ready), 32'(0));
          if (rsp_ready) begin
            if (q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_rsp actual=%0h required=no_response", rsp_result);
            end else begin
              e = q.pop_front();
              chk("rsp_result", 32'(rsp_result), 32'(e.r));
              chk("rsp_flags", 32'({rsp_carry_out, rsp_overflow}), 32'({e.co, e.ov}));
            end
          end
        end
        held_valid = rsp_valid && !rsp_ready;
        held = {rsp_result, rsp_carry_out, rsp_overflow};
      end
    end
  end

  task automatic accept(input logic [2:0] sel, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++;
      $display("FAIL accept_timeout actual=req_ready_low required=req_ready_high");
      return;
    end
    chk("idle_alu_zero", 32'({alu_sel, alu_carry_in, alu_port_a, alu_port_b}), 32'(0));
    req_sel = sel; req_carry_in = ci; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    q.push_back(ref_model(sel, ci, a, b));
    // Keep a garbage request pending during RUN; it must be ignored.
    req_sel = 3'($urandom); req_carry_in = 1'($urandom);
    req_a = W'($urandom); req_b = W'($urandom);
    ok = 1'b1;
  endtask

  task automatic run_checks(input logic [2:0] sel, input logic ci,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] pa, pb;
    bit sel_ok, busy;
    pa = '0; pb = '0; sel_ok = 1'b1; busy = 1'b0;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      pa[k*OW +: OW] = alu_port_a;
      pb[k*OW +: OW] = alu_port_b;
      if (k == 0) chk("slice0_carry_in", 32'(alu_carry_in), 32'(ci));
      sel_ok = sel_ok && (alu_sel == sel);
      busy   = busy || rsp_valid || req_ready;
    end
    chk("port_a_seq", 32'(pa), 32'(a));
    chk("port_b_seq", 32'(pb), 32'(b));
    chk("run_sel", 32'(sel_ok), 32'(1));
    chk("run_no_valid_ready", 32'(busy), 32'(0));
    @(negedge clk);
    chk("latency_valid", 32'(rsp_valid), 32'(1));
    req_valid = 1'b0;
  endtask

  task automatic do_txn(input logic [2:0] sel, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    accept(sel, ci, a, b, ok);
    if (ok) run_checks(sel, ci, a, b);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || !req_ready) && n < 200) begin @(negedge clk); n++; end
    chk("drain", 32'(q.size()), 32'(0));
  endtask

  typedef struct packed {
    logic [2:0]   sel;
    logic         ci;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t vecs[8] = '{
    '{3'b011, 1'b0, 16'h1234, 16'h0FFF},
    '{3'b011, 1'b0, 16'h7FFF, 16'h0001},
    '{3'b011, 1'b0, 16'hFFFF, 16'h0001},
    '{3'b010, 1'b1, 16'h0005, 16'h0007},
    '{3'b001, 1'b1, 16'h0005, 16'h0007},
    '{3'b111, 1'b0, 16'h1234, 16'h5678},
    '{3'b000, 1'b0, 16'h1234, 16'h5678},
    '{3'b100, 1'b0, 16'hF0F0, 16'hFF00}
  };

  initial begin
    bit ok, seen;
    rst = 1'b1; req_valid = 1'b0; req_sel = '0; req_carry_in = 1'b0;
    req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_alu_zero", 32'({alu_sel, alu_carry_in, alu_port_a, alu_port_b}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'(1));
    chk("reset_rsp_regs", 32'({rsp_result, rsp_carry_out, rsp_overflow}), 32'(0));

    foreach (vecs[i]) do_txn(vecs[i].sel, vecs[i].ci, vecs[i].a, vecs[i].b);
    for (int i = 0; i < 30; i++)
      do_txn(3'($urandom_range(0, 7)), 1'($urandom), W'($urandom), W'($urandom));

    // Backpressure: hold the response for three extra cycles.
    wait_drain();
    bp_mode = 1;
    do_txn(3'b011, 1'b0, 16'h1234, 16'h0FFF);
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_a = W'($urandom); req_b = W'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_req_ready", 32'(req_ready), 32'(0));
    end
    req_valid = 1'b0;
    bp_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_back_to_idle", 32'({req_ready, rsp_valid}), 32'({1'b1, 1'b0}));
    bp_mode = 0;

    // Reset two slices into a run: the operation is dropped.
    wait_drain();
    accept(3'b011, 1'b0, 16'h1234, 16'h0FFF, ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      rst = 1'b1; req_valid = 1'b0;
      void'(q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      chk("abort_req_ready", 32'(req_ready), 32'(1));
      chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("abort_port_a", 32'(alu_port_a), 32'(0));
      chk("abort_rsp_result", 32'(rsp_result), 32'(0));
      seen = 1'b0;
      repeat (NS + 3) begin @(negedge clk); seen = seen || rsp_valid; end
      chk("abort_no_rsp", 32'(seen), 32'(0));
    end
    do_txn(3'b011, 1'b0, 16'h0001, 16'h0001);

    wait_drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_74382_slice_seq.md
ALU_74382_SLICE_SEQ -- requirements
Module: alu_74382_slice_seq

Interface
REQ-001 Parameter OPERAND_W, default 4: width of one 74382 slice, matching the alu_74382 OPERAND_W it drives.
REQ-002 Parameter WORD_W, default 16: full operand/result width; NSLICE = WORD_W/OPERAND_W.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept request.
REQ-007 req_sel  in  3  74382 function code, applied to every slice.
REQ-008 req_carry_in  in  1  carry into least-significant slice.
REQ-009 req_a, req_b  in  WORD_W  full-width operands.
REQ-010 alu_sel  out  3  to alu_74382 sel.
REQ-011 alu_carry_in  out  1  to alu_74382 carry_in.
REQ-012 alu_port_a, alu_port_b  out  OPERAND_W  current operand slices to alu_74382.
REQ-013 alu_result  in  OPERAND_W  from alu_74382 result, combinational within the same cycle.
REQ-014 alu_overflow, alu_carry_out  in  1  from alu_74382 overflow/carry_out.
REQ-015 rsp_valid  out  1  response present.
REQ-016 rsp_ready  in  1  consumer accepts response.
REQ-017 rsp_result  out  WORD_W  assembled result.
REQ-018 rsp_carry_out, rsp_overflow  out  1  carry and overflow reported by the most-significant slice.

Function
REQ-019 WORD_W not an integer multiple of OPERAND_W, or NSLICE < 1, SHALL raise an elaboration error.
REQ-020 FSM states: IDLE, RUN, DONE; req_ready = 1 only in IDLE; rsp_valid = 1 only in DONE.
REQ-021 IDLE: on req_valid=1, capture req_sel, req_a, req_b, req_carry_in into internal registers; set slice index to 0 and carry register to req_carry_in; go to RUN.
REQ-022 RUN, slice index i: alu_sel = captured sel, alu_port_a/b = captured operand bits [i*OPERAND_W +: OPERAND_W], alu_carry_in = carry register.
REQ-023 RUN, each edge: alu_result is written to result bits of slice i; carry register <= alu_carry_out; i increments.
REQ-024 RUN, at i = NSLICE-1: additionally rsp_carry_out <= alu_carry_out and rsp_overflow <= alu_overflow; go to DONE.
REQ-025 Latency: rsp_valid rises exactly NSLICE cycles after the accepting edge (4 for defaults); input-to-input throughput is at best one request per NSLICE+2 cycles.
REQ-026 DONE: rsp_result, rsp_carry_out and rsp_overflow are held stable while rsp_valid=1 and rsp_ready=0; on rsp_ready=1, go to IDLE.
REQ-027 Outside RUN: alu_sel = 3'b000, alu_carry_in = 0, alu_port_a = alu_port_b = 0.
REQ-028 req_valid in RUN or DONE is ignored, with no capture and no side effect; the request must be held until req_ready=1.
REQ-029 Captured operands do not change during RUN regardless of req_* activity.
REQ-030 Carry chaining is identical for all sel codes; flags from logic/CLEAR/PRESET codes are passed through unmodified from the top slice.
REQ-031 Slices are processed least-significant first; index wraps to 0 only via a new accept.

Reset
REQ-032 With rst=1 at an edge: state <= IDLE, index <= 0, carry register <= 0, rsp_result <= 0, rsp_carry_out <= 0, rsp_overflow <= 0.
REQ-033 During and after reset: req_ready = 1 (once rst=0), rsp_valid = 0, alu_* outputs per REQ-027.
REQ-034 Reset during RUN or DONE aborts the operation; no response is issued for it, and rst has priority over every other event at the same edge.

Verification (WORD_W=16, OPERAND_W=4, real alu_74382 connected)
REQ-035 ADD: sel=011, ci=0, A=0x1234, B=0x0FFF -> rsp_result=0x2233, carry_out=0, overflow=0, rsp_valid 4 cycles after accept; alu_port_a sequence is 0x4, 0x3, 0x2, 0x1.
REQ-036 Signed overflow: sel=011, ci=0, A=0x7FFF, B=0x0001 -> 0x8000, carry_out=0, overflow=1; also A=0xFFFF, B=0x0001 -> 0x0000, carry_out=1, overflow=0.
REQ-037 SUB: sel=010 (A minus B), ci=1, A=0x0005, B=0x0007 -> 0xFFFE, carry_out=0; sel=001 (B minus A) with the same operands -> 0x0002, carry_out=1.
REQ-038 PRESET/CLEAR/logic: sel=111 -> 0xFFFF; sel=000 -> 0x0000; sel=100, A=0xF0F0, B=0xFF00 -> 0x0FF0.
REQ-039 Backpressure: rsp_ready=0 for 3 cycles in DONE -> outputs stable, req_ready=0, extra req_valid ignored; a response is issued on rsp_ready=1 and IDLE is entered on the next cycle.
REQ-040 Reset mid-RUN: assert rst after 2 slices -> next cycle req_ready=1, rsp_valid=0, alu_port_a=0; a subsequent ADD of 0x0001+0x0001 returns 0x0002.
